// File: rtl/vram_pkg.sv
// Shared VRAM geometry, host command record and arbiter state encoding.
package vram_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;
  localparam int VRAM_DEPTH  = 32768;

  // Host command as stored in the command FIFO (24 bits).
  typedef struct packed {
    logic                   we;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] wdata;
  } host_cmd_t;

  typedef enum logic [1:0] {
    RENDER = 2'd0,
    GUARD  = 2'd1,
    HOST   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vram_port_arbiter_if.sv
// Host command port: request handshake plus read response strobe.
interface vram_port_arbiter_if;
  import vram_pkg::*;

  logic                   host_valid;
  logic                   host_ready;
  logic                   host_we;
  logic [VRAM_ADDR_W-1:0] host_addr;
  logic [VRAM_DATA_W-1:0] host_wdata;
  logic                   host_rvalid;
  logic [VRAM_DATA_W-1:0] host_rdata;

  modport master (
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/vram_cmd_fifo.sv
// Synchronous host command FIFO; pointers carry one extra wrap bit.
module vram_cmd_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  host_cmd_t din_i,
  input  logic      pop_i,
  output host_cmd_t dout_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int AW = $clog2(DEPTH);

  host_cmd_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; overflow/underflow requests are ignored.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // Pointer registers; reset flushes the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: renderer has priority, host commands drain
// from a FIFO during renderer idle time after a guard interval.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   render_busy,
  input  logic [VRAM_ADDR_W-1:0] render_addr,
  output logic [VRAM_DATA_W-1:0] render_data,
  vram_port_arbiter_if.slave     host,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic                   vram_we,
  output logic [VRAM_DATA_W-1:0] vram_din,
  input  logic [VRAM_DATA_W-1:0] vram_dout
);
  arb_state_t state_q;
  logic [1:0] idle_q;
  logic       rvalid_q;
  logic       fifo_full, fifo_empty, push, issue;
  host_cmd_t  head, push_cmd;

  assign push_cmd    = '{we: host.host_we, addr: host.host_addr, wdata: host.host_wdata};
  assign push        = host.host_valid && host.host_ready;
  assign host.host_ready  = !fifo_full && !rst;
  assign host.host_rvalid = rvalid_q;
  assign host.host_rdata  = rvalid_q ? vram_dout : '0;
  assign render_data = vram_dout;

  vram_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_cmd),
    .pop_i   (issue),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Port mux: renderer by default, FIFO head when the host may issue.
  always_comb begin
    issue     = (state_q == HOST) && !render_busy && !fifo_empty;
    vram_addr = render_addr;
    vram_we   = 1'b0;
    vram_din  = '0;
    if (issue) begin
      vram_addr = head.addr;
      vram_we   = head.we;
      vram_din  = head.wdata;
    end
  end

  // Ownership FSM. idle_q counts idle cycles since busy fell, including
  // the RENDER cycle that first saw it low, so access is granted exactly
  // GUARD_CYCLES cycles after the fall (GUARD is skipped when that is <=1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RENDER;
      idle_q  <= '0;
    end else begin
      case (state_q)
        RENDER: begin
          if (!render_busy) begin
            if (GUARD_CYCLES <= 1) begin
              state_q <= HOST;
              idle_q  <= '0;
            end else begin
              state_q <= GUARD;
              idle_q  <= 2'd1;
            end
          end
        end
        GUARD: begin
          if (render_busy) begin
            state_q <= RENDER;
            idle_q  <= '0;
          end else if (int'(idle_q) + 1 >= GUARD_CYCLES) begin
            state_q <= HOST;
            idle_q  <= '0;
          end else begin
            idle_q  <= idle_q + 2'd1;
          end
        end
        HOST: begin
          if (render_busy) state_q <= RENDER;
        end
        default: begin
          state_q <= RENDER;
          idle_q  <= '0;
        end
      endcase
    end
  end

  // Read response strobe one cycle after a host read issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rvalid_q <= 1'b0;
    else     rvalid_q <= issue && !head.we;
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Scoreboard bench for vram_port_arbiter with a behavioural VRAM and a
// reference model based on idle run length and a queue of host commands.
module tb_vram_port_arbiter;
  import vram_pkg::*;

  localparam int DEPTH = 4;
  localparam int GUARD = 3;
  localparam int M     = (GUARD < 1) ? 1 : GUARD;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   render_busy;
  logic [VRAM_ADDR_W-1:0] render_addr;
  logic [VRAM_DATA_W-1:0] render_data;
  logic [VRAM_ADDR_W-1:0] vram_addr;
  logic                   vram_we;
  logic [VRAM_DATA_W-1:0] vram_din;
  logic [VRAM_DATA_W-1:0] vram_dout;

  vram_port_arbiter_if hif();

  vram_port_arbiter #(.FIFO_DEPTH(DEPTH), .GUARD_CYCLES(GUARD)) dut (
    .clk         (clk),
    .rst         (rst),
    .render_busy (render_busy),
    .render_addr (render_addr),
    .render_data (render_data),
    .host        (hif.slave),
    .vram_addr   (vram_addr),
    .vram_we     (vram_we),
    .vram_din    (vram_din),
    .vram_dout   (vram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [14:0] a);
    return a[7:0] ^ {a[14:8], 1'b1};
  endfunction

  // Write-first synchronous VRAM.
  logic [7:0] ram [VRAM_DEPTH];
  initial begin
    for (int i = 0; i < VRAM_DEPTH; i++) ram[i] = init_val(15'(i));
    vram_dout = '0;
    forever begin
      @(posedge clk);
      if (vram_we) begin
        ram[vram_addr] <= vram_din;
        vram_dout      <= vram_din;
      end else begin
        vram_dout      <= ram[vram_addr];
      end
    end
  end

  typedef struct {
    int         cyc;
    logic [14:0] addr;
    logic        we;
    logic [7:0]  din;
    logic        ready;
    logic        rchk;
    logic [7:0]  rdat;
  } exp_t;
  typedef struct {
    int         cyc;
    logic [7:0] data;
  } rd_t;

  exp_t      cyc_q[$];
  rd_t       rd_q[$];
  host_cmd_t fifo_m[$];
  host_cmd_t pend[$];
  logic [7:0] shadow [VRAM_DEPTH];
  int  run = 0;
  int  cyc = 0;
  bit  prev_rend = 1'b0;
  logic [14:0] prev_raddr = '0;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic check(input string name, input int cy, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cy, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus reference-model prediction.
  task automatic step(input bit busy, input bit r);
    exp_t e;
    host_cmd_t c;
    bit issue;
    @(posedge clk);
    #1;
    rst = r;
    if (r) pend.delete();
    render_busy = busy;
    render_addr = 15'($urandom);
    hif.host_valid = (pend.size() > 0);
    if (pend.size() > 0) begin
      hif.host_we    = pend[0].we;
      hif.host_addr  = pend[0].addr;
      hif.host_wdata = pend[0].wdata;
    end else begin
      hif.host_we    = 1'($urandom);
      hif.host_addr  = 15'($urandom);
      hif.host_wdata = 8'($urandom);
    end
    e.cyc  = cyc;
    e.rchk = prev_rend && (cyc > 0);
    e.rdat = shadow[prev_raddr];
    if (r) begin
      run = 0;
      fifo_m.delete();
      while (rd_q.size() > 0 && rd_q[rd_q.size()-1].cyc >= cyc) void'(rd_q.pop_back());
      e.ready = 1'b0;
      issue = 1'b0;
    end else begin
      if (busy) run = 0; else run++;
      e.ready = (fifo_m.size() < DEPTH);
      issue = (run >= M + 1) && (fifo_m.size() > 0);
    end
    if (issue) begin
      c = fifo_m.pop_front();
      e.addr = c.addr;
      e.we   = c.we;
      e.din  = c.we ? c.wdata : c.wdata;
      if (c.we) shadow[c.addr] = c.wdata;
      else      rd_q.push_back('{cyc: cyc + 1, data: shadow[c.addr]});
    end else begin
      e.addr = render_addr;
      e.we   = 1'b0;
      e.din  = '0;
    end
    prev_rend  = !issue;
    prev_raddr = render_addr;
    if (!r && e.ready && hif.host_valid) fifo_m.push_back(pend.pop_front());
    cyc_q.push_back(e);
    cyc++;
  endtask

  task automatic steps(input int n, input bit busy);
    for (int i = 0; i < n; i++) step(busy, 1'b0);
  endtask

  // Monitor: compares the port against the predicted record each cycle.
  initial begin
    exp_t e;
    bit rv;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        check("vram_addr", e.cyc, 32'(vram_addr), 32'(e.addr));
        check("vram_we", e.cyc, 32'(vram_we), 32'(e.we));
        check("vram_din", e.cyc, 32'(vram_din), 32'(e.din));
        check("host_ready", e.cyc, 32'(hif.host_ready), 32'(e.ready));
        if (e.rchk) check("render_data", e.cyc, 32'(render_data), 32'(e.rdat));
        rv = (rd_q.size() > 0) && (rd_q[0].cyc == e.cyc);
        check("host_rvalid", e.cyc, 32'(hif.host_rvalid), 32'(rv));
        if (rv) begin
          if (hif.host_rvalid) check("host_rdata", e.cyc, 32'(hif.host_rdata), 32'(rd_q[0].data));
          void'(rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < VRAM_DEPTH; i++) shadow[i] = init_val(15'(i));
    rst            = 1'b1;
    render_busy    = 1'b1;
    render_addr    = '0;
    hif.host_valid = 1'b0;
    hif.host_we    = 1'b0;
    hif.host_addr  = '0;
    hif.host_wdata = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

    // Writes in blanking.
    steps(6, 1'b0);
    pend.push_back('{we: 1'b1, addr: 15'h0123, wdata: 8'hA5});
    steps(4, 1'b0);

    // Read back from the top address.
    pend.push_back('{we: 1'b1, addr: 15'h7FFF, wdata: 8'h3C});
    pend.push_back('{we: 1'b0, addr: 15'h7FFF, wdata: 8'h00});
    steps(6, 1'b0);

    // Render priority: FIFO fills while busy, drains after guard.
    for (int i = 0; i < 5; i++)
      pend.push_back('{we: 1'b1, addr: 15'(16 + i), wdata: 8'(8'h40 + i)});
    steps(8, 1'b1);
    steps(12, 1'b0);

    // Preemption after the first of two reads.
    pend.push_back('{we: 1'b0, addr: 15'h0123, wdata: 8'h00});
    pend.push_back('{we: 1'b0, addr: 15'h7FFF, wdata: 8'h00});
    steps(4, 1'b1);
    steps(M + 1, 1'b0);
    steps(3, 1'b1);
    steps(8, 1'b0);

    // Reset with queued commands and a read in flight.
    pend.push_back('{we: 1'b0, addr: 15'h0010, wdata: 8'h00});
    for (int i = 0; i < 3; i++)
      pend.push_back('{we: 1'b1, addr: 15'(32 + i), wdata: 8'hEE});
    steps(5, 1'b1);
    steps(M + 1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    steps(8, 1'b0);

    // Guard interval: short idle gaps must not grant the port.
    pend.push_back('{we: 1'b1, addr: 15'h0200, wdata: 8'h11});
    pend.push_back('{we: 1'b1, addr: 15'h0201, wdata: 8'h22});
    steps(3, 1'b1);
    steps(2, 1'b0);
    steps(2, 1'b1);
    steps(M + 1, 1'b0);
    steps(3, 1'b1);
    steps(8, 1'b0);

    // Randomised traffic with bursty renderer and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (pend.size() < 3 && $urandom_range(0, 2) == 0)
        pend.push_back('{we: 1'($urandom),
                         addr: ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 15)),
                         wdata: 8'($urandom)});
      if ($urandom_range(0, 499) == 0) begin
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
      end else begin
        step(($urandom_range(0, 9) < 4) ? ~render_busy : render_busy, 1'b0);
      end
    end

    pend.delete();
    steps(20, 1'b0);
    @(negedge clk);
    #1;
    check("rd_queue_drained", cyc, rd_q.size(), 0);
    check("fifo_model_drained", cyc, fifo_m.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
